// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with a memory request/ready handshake, a memory
// timeout watchdog and sticky fault trapping for illegal instructions/timeouts.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned EN_SHIFT    = 1
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemtoReg,
  output logic        IorD,
  output logic [1:0]  RegDst,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  Branch,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ExtOp,
  output logic [1:0]  alu_op,
  output logic [5:0]  alu_funct,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        retire,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StItypeEx  = 4'd9,
    StItypeWb  = 4'd10,
    StJump     = 4'd11,
    StJr       = 4'd12,
    StJal      = 4'd13,
    StFault    = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpJal   = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpSlti  = 6'hA;
  localparam logic [5:0] OpAndi  = 6'hC;
  localparam logic [5:0] OpOri   = 6'hD;
  localparam logic [5:0] OpXori  = 6'hE;
  localparam logic [5:0] OpLui   = 6'hF;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  localparam logic [1:0] CodeIllegal = 2'd1;
  localparam logic [1:0] CodeTimeout = 2'd2;

  state_e          r_state, w_next;
  logic [TO_W-1:0] r_wait, w_wait;
  logic            r_fault;
  logic [1:0]      r_fault_code, w_code;

  logic [5:0] w_op, w_funct;
  logic       w_is_shift, w_sign_ext, w_timeout, w_to_fault;
  logic       w_unused_instr;

  assign w_op           = instr[31:26];
  assign w_funct        = instr[5:0];
  assign w_unused_instr = ^instr[25:6];
  assign w_is_shift     = (w_funct == 6'd0) || (w_funct == 6'd2) || (w_funct == 6'd3);
  assign w_sign_ext     = (w_op == OpAddi) || (w_op == OpSlti);
  // Last permitted wait cycle: no ready now means the access has timed out.
  assign w_timeout      = !mem_ready && (r_wait == TO_W'(MEM_TIMEOUT));
  assign w_to_fault     = (w_next == StFault) && (r_state != StFault);

  // State, wait counter and sticky fault registers.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      r_state      <= StFetch;
      r_wait       <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait;
      if (w_to_fault) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_code;
      end
    end
  end

  // Next-state decode and fault cause selection.
  always_comb begin
    w_next = r_state;
    w_code = 2'd0;
    unique case (r_state)
      StFetch, StMemRead, StMemWrite: begin
        if (mem_ready) begin
          unique case (r_state)
            StFetch:   w_next = StDecode;
            StMemRead: w_next = StMemWb;
            default:   w_next = StFetch;
          endcase
        end else if (w_timeout) begin
          w_next = StFault;
          w_code = CodeTimeout;
        end
      end
      StDecode: begin
        case (w_op)
          OpLw, OpSw:                                   w_next = StMemAdr;
          OpRtype:                                      w_next = StExecute;
          OpBeq, OpBne:                                 w_next = StBranch;
          OpAddi, OpSlti, OpAndi, OpOri, OpXori, OpLui: w_next = StItypeEx;
          OpJ:                                          w_next = StJump;
          OpJal:                                        w_next = StJal;
          default: begin
            w_next = StFault;
            w_code = CodeIllegal;
          end
        endcase
      end
      StMemAdr:  w_next = (w_op == OpLw) ? StMemRead : StMemWrite;
      StExecute: begin
        if (w_funct == 6'd8) begin
          w_next = StJr;
        end else if (w_funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42}) begin
          w_next = StAluWb;
        end else if (w_is_shift && (EN_SHIFT != 0)) begin
          w_next = StAluWb;
        end else begin
          w_next = StFault;
          w_code = CodeIllegal;
        end
      end
      StItypeEx: w_next = StItypeWb;
      StMemWb, StAluWb, StBranch, StItypeWb, StJump, StJr, StJal: w_next = StFetch;
      StFault:   w_next = StFault;
      default:   w_next = StFetch;
    endcase
  end

  // Wait counter: restarts on any state change, counts unanswered request cycles.
  always_comb begin
    w_wait = '0;
    if ((w_next == r_state) && mem_req && !mem_ready) begin
      w_wait = r_wait + TO_W'(1);
    end
  end

  // Moore datapath controls, with instr-dependent fields where needed.
  always_comb begin
    mem_req   = 1'b0;
    MemtoReg  = 1'b0;
    IorD      = 1'b0;
    RegDst    = 2'b00;
    PCSrc     = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    Branch    = 2'b00;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ExtOp     = 1'b0;
    alu_op    = 2'b00;
    alu_funct = 6'd0;
    retire    = 1'b0;
    unique case (r_state)
      StFetch: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode:  ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      StMemRead: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      StExecute: begin
        ALUSrcA   = w_is_shift ? 2'b10 : 2'b01;
        alu_op    = 2'b10;
        alu_funct = w_funct;
      end
      StAluWb: begin
        RegDst    = 2'b01;
        RegWrite  = 1'b1;
        alu_funct = w_funct;
        retire    = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 2'b01;
        PCSrc   = 2'b01;
        alu_op  = 2'b01;
        Branch  = {w_op == OpBne, w_op == OpBeq};
        retire  = 1'b1;
      end
      StItypeEx: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        alu_op    = 2'b11;
        alu_funct = w_op;
        ExtOp     = w_sign_ext;
      end
      StItypeWb: begin
        RegWrite  = 1'b1;
        alu_funct = w_op;
        ExtOp     = w_sign_ext;
        retire    = 1'b1;
      end
      StJump: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
      end
      StJr: begin
        PCSrc   = 2'b11;
        PCWrite = 1'b1;
        retire  = 1'b1;
      end
      StJal: begin
        PCSrc    = 2'b10;
        PCWrite  = 1'b1;
        RegDst   = 2'b10;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
    // A trapping cycle must not commit any architectural state.
    if (w_to_fault) begin
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: table of per-cycle vectors plus hand-written
// sequences for timeout, fault stickiness, reset and the shift-disabled variant.
module tb_mc_control_fsm;

  logic        cclk = 1'b0;
  logic        rstb;
  logic [31:0] instr;
  logic        mem_ready;

  logic       mem_req, MemtoReg, IorD, IRWrite, MemWrite, PCWrite, RegWrite, ExtOp;
  logic       fault, retire;
  logic [1:0] RegDst, PCSrc, ALUSrcA, ALUSrcB, Branch, alu_op, fault_code;
  logic [5:0] alu_funct;
  logic [3:0] state_o;

  logic       n_mem_req, n_MemtoReg, n_IorD, n_IRWrite, n_MemWrite, n_PCWrite, n_RegWrite;
  logic       n_ExtOp, n_fault, n_retire;
  logic [1:0] n_RegDst, n_PCSrc, n_ALUSrcA, n_ALUSrcB, n_Branch, n_alu_op, n_fault_code;
  logic [5:0] n_alu_funct;
  logic [3:0] n_state_o;
  logic       unused_ns;

  always #5 cclk = ~cclk;

  mc_control_fsm #(.MEM_TIMEOUT(15), .TO_W(8), .EN_SHIFT(1)) dut (
    .cclk(cclk), .rstb(rstb), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemtoReg(MemtoReg), .IorD(IorD), .RegDst(RegDst), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Branch(Branch), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .alu_op(alu_op), .alu_funct(alu_funct), .fault(fault), .fault_code(fault_code),
    .retire(retire), .state_o(state_o)
  );

  mc_control_fsm #(.MEM_TIMEOUT(15), .TO_W(8), .EN_SHIFT(0)) dut_ns (
    .cclk(cclk), .rstb(rstb), .instr(instr), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .MemtoReg(n_MemtoReg), .IorD(n_IorD), .RegDst(n_RegDst),
    .PCSrc(n_PCSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .Branch(n_Branch),
    .IRWrite(n_IRWrite), .MemWrite(n_MemWrite), .PCWrite(n_PCWrite),
    .RegWrite(n_RegWrite), .ExtOp(n_ExtOp), .alu_op(n_alu_op), .alu_funct(n_alu_funct),
    .fault(n_fault), .fault_code(n_fault_code), .retire(n_retire), .state_o(n_state_o)
  );

  assign unused_ns = ^{n_mem_req, n_MemtoReg, n_IorD, n_IRWrite, n_MemWrite, n_PCWrite,
                       n_RegWrite, n_ExtOp, n_retire, n_RegDst, n_PCSrc, n_ALUSrcA,
                       n_ALUSrcB, n_Branch, n_alu_op, n_alu_funct};

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       IorD;
    logic       MemtoReg;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] Branch;
    logic       IRWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       ExtOp;
    logic [1:0] alu_op;
    logic [5:0] alu_funct;
    logic       fault;
    logic [1:0] fault_code;
    logic       retire;
  } outs_t;

  typedef struct {
    string       name;
    logic        rstb;
    logic [31:0] instr;
    logic        rdy;
    outs_t       exp;
  } vec_t;

  outs_t obs;
  assign obs = {state_o, mem_req, IorD, MemtoReg, RegDst, PCSrc, ALUSrcA, ALUSrcB, Branch,
                IRWrite, MemWrite, PCWrite, RegWrite, ExtOp, alu_op, alu_funct, fault,
                fault_code, retire};

  localparam logic [31:0] ILw   = 32'h8C22_0004;
  localparam logic [31:0] ISw   = 32'hAC22_0004;
  localparam logic [31:0] IAdd  = 32'h0022_1820;
  localparam logic [31:0] ISll  = 32'h0002_1080;
  localparam logic [31:0] IBne  = 32'h1422_0003;
  localparam logic [31:0] IBeq  = 32'h1022_0003;
  localparam logic [31:0] IOri  = 32'h3422_FFFF;
  localparam logic [31:0] IAddi = 32'h2042_0001;
  localparam logic [31:0] IJal  = 32'h0C00_0010;
  localparam logic [31:0] IJ    = 32'h0800_0010;
  localparam logic [31:0] IJr   = 32'h03E0_0008;
  localparam logic [31:0] IIll  = 32'hFC00_0000;

  localparam outs_t KFetch    = '{st: 4'd0, mem_req: 1'b1, ALUSrcB: 2'b01, default: '0};
  localparam outs_t KFetchRdy = '{st: 4'd0, mem_req: 1'b1, ALUSrcB: 2'b01, IRWrite: 1'b1,
                                  PCWrite: 1'b1, default: '0};
  localparam outs_t KDecode   = '{st: 4'd1, ALUSrcB: 2'b11, default: '0};
  localparam outs_t KMemAdr   = '{st: 4'd2, ALUSrcA: 2'b01, ALUSrcB: 2'b10, ExtOp: 1'b1,
                                  default: '0};
  localparam outs_t KMemRd    = '{st: 4'd3, mem_req: 1'b1, IorD: 1'b1, default: '0};
  localparam outs_t KMemWr    = '{st: 4'd5, mem_req: 1'b1, IorD: 1'b1, MemWrite: 1'b1,
                                  default: '0};
  localparam outs_t KFltIll   = '{st: 4'd15, fault: 1'b1, fault_code: 2'd1, default: '0};
  localparam outs_t KFltTo    = '{st: 4'd15, fault: 1'b1, fault_code: 2'd2, default: '0};

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input string n, input logic r, input logic [31:0] i,
                              input logic rdy, input outs_t e);
    vec_t v;
    v.name = n; v.rstb = r; v.instr = i; v.rdy = rdy; v.exp = e;
    vq.push_back(v);
  endfunction

  // Fetch completing immediately, followed by the decode cycle.
  function automatic void fd(input string n, input logic [31:0] i);
    add({n, "-fetch"}, 1'b1, i, 1'b1, KFetchRdy);
    add({n, "-decode"}, 1'b1, i, 1'b0, KDecode);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one cycle's inputs, check outputs before the edge, then clock.
  task automatic step(input string name, input logic r, input logic [31:0] i,
                      input logic rdy, input outs_t e);
    @(negedge cclk);
    rstb = r; instr = i; mem_ready = rdy;
    #1;
    check(name, 64'(obs), 64'(e));
    @(posedge cclk);
  endtask

  initial begin
    outs_t e;
    rstb = 1'b0; instr = 32'h0; mem_ready = 1'b0;
    repeat (2) @(posedge cclk);

    // LW with three wait cycles in both FETCH and MEM_READ.
    for (int k = 0; k < 3; k++) add("lw-fetch-wait", 1'b1, ILw, 1'b0, KFetch);
    fd("lw", ILw);
    add("lw-memadr", 1'b1, ILw, 1'b0, KMemAdr);
    for (int k = 0; k < 3; k++) add("lw-memrd-wait", 1'b1, ILw, 1'b0, KMemRd);
    add("lw-memrd-rdy", 1'b1, ILw, 1'b1, KMemRd);
    add("lw-memwb", 1'b1, ILw, 1'b0,
        '{st: 4'd4, MemtoReg: 1'b1, RegWrite: 1'b1, retire: 1'b1, default: '0});
    fd("add", IAdd);
    add("add-exec", 1'b1, IAdd, 1'b0,
        '{st: 4'd6, ALUSrcA: 2'b01, alu_op: 2'b10, alu_funct: 6'h20, default: '0});
    add("add-wb", 1'b1, IAdd, 1'b0,
        '{st: 4'd7, RegDst: 2'b01, RegWrite: 1'b1, alu_funct: 6'h20, retire: 1'b1,
          default: '0});
    fd("sll", ISll);
    add("sll-exec", 1'b1, ISll, 1'b0,
        '{st: 4'd6, ALUSrcA: 2'b10, alu_op: 2'b10, alu_funct: 6'h00, default: '0});
    add("sll-wb", 1'b1, ISll, 1'b0,
        '{st: 4'd7, RegDst: 2'b01, RegWrite: 1'b1, retire: 1'b1, default: '0});
    fd("bne", IBne);
    add("bne-branch", 1'b1, IBne, 1'b0,
        '{st: 4'd8, ALUSrcA: 2'b01, PCSrc: 2'b01, alu_op: 2'b01, Branch: 2'b10,
          retire: 1'b1, default: '0});
    fd("beq", IBeq);
    add("beq-branch", 1'b1, IBeq, 1'b0,
        '{st: 4'd8, ALUSrcA: 2'b01, PCSrc: 2'b01, alu_op: 2'b01, Branch: 2'b01,
          retire: 1'b1, default: '0});
    fd("ori", IOri);
    add("ori-ex", 1'b1, IOri, 1'b0,
        '{st: 4'd9, ALUSrcA: 2'b01, ALUSrcB: 2'b10, alu_op: 2'b11, alu_funct: 6'h0D,
          default: '0});
    add("ori-wb", 1'b1, IOri, 1'b0,
        '{st: 4'd10, RegWrite: 1'b1, alu_funct: 6'h0D, retire: 1'b1, default: '0});
    fd("addi", IAddi);
    add("addi-ex", 1'b1, IAddi, 1'b0,
        '{st: 4'd9, ALUSrcA: 2'b01, ALUSrcB: 2'b10, alu_op: 2'b11, alu_funct: 6'h08,
          ExtOp: 1'b1, default: '0});
    add("addi-wb", 1'b1, IAddi, 1'b0,
        '{st: 4'd10, RegWrite: 1'b1, alu_funct: 6'h08, ExtOp: 1'b1, retire: 1'b1,
          default: '0});
    fd("jal", IJal);
    add("jal", 1'b1, IJal, 1'b0,
        '{st: 4'd13, PCSrc: 2'b10, PCWrite: 1'b1, RegDst: 2'b10, RegWrite: 1'b1,
          retire: 1'b1, default: '0});
    fd("j", IJ);
    add("j", 1'b1, IJ, 1'b0,
        '{st: 4'd11, PCSrc: 2'b10, PCWrite: 1'b1, retire: 1'b1, default: '0});
    fd("jr", IJr);
    add("jr-exec", 1'b1, IJr, 1'b0,
        '{st: 4'd6, ALUSrcA: 2'b01, alu_op: 2'b10, alu_funct: 6'h08, default: '0});
    add("jr", 1'b1, IJr, 1'b0,
        '{st: 4'd12, PCSrc: 2'b11, PCWrite: 1'b1, retire: 1'b1, default: '0});
    fd("sw", ISw);
    add("sw-memadr", 1'b1, ISw, 1'b0, KMemAdr);
    add("sw-memwr-wait", 1'b1, ISw, 1'b0, KMemWr);
    e = KMemWr; e.retire = 1'b1;
    add("sw-memwr-rdy", 1'b1, ISw, 1'b1, e);

    foreach (vq[k]) step(vq[k].name, vq[k].rstb, vq[k].instr, vq[k].rdy, vq[k].exp);

    // FETCH timeout: 16 unanswered request cycles, then sticky FAULT.
    for (int k = 0; k < 16; k++) step("to-fetch-wait", 1'b1, ILw, 1'b0, KFetch);
    step("to-fault-a", 1'b1, IAdd, 1'b1, KFltTo);
    step("to-fault-b", 1'b1, IIll, 1'b0, KFltTo);
    step("to-fault-c", 1'b1, ILw, 1'b1, KFltTo);
    step("rst-in-fault", 1'b0, ILw, 1'b1, KFltTo);

    // Ready arriving on the 16th request cycle wins; then an illegal opcode.
    for (int k = 0; k < 15; k++) step("edge-fetch-wait", 1'b1, IIll, 1'b0, KFetch);
    step("edge-fetch-rdy", 1'b1, IIll, 1'b1, KFetchRdy);
    step("ill-decode", 1'b1, IIll, 1'b0, KDecode);
    step("ill-fault-a", 1'b1, IAdd, 1'b1, KFltIll);
    step("ill-fault-b", 1'b1, ILw, 1'b0, KFltIll);
    step("rst-ill", 1'b0, ILw, 1'b0, KFltIll);

    // Reset mid-wait in MEM_READ returns to a clean FETCH with a cleared counter.
    step("mr-fetch", 1'b1, ILw, 1'b1, KFetchRdy);
    step("mr-decode", 1'b1, ILw, 1'b0, KDecode);
    step("mr-memadr", 1'b1, ILw, 1'b0, KMemAdr);
    step("mr-wait-a", 1'b1, ILw, 1'b0, KMemRd);
    step("mr-wait-b", 1'b1, ILw, 1'b0, KMemRd);
    step("mr-rst", 1'b0, ILw, 1'b0, KMemRd);
    for (int k = 0; k < 15; k++) step("post-rst-wait", 1'b1, ISw, 1'b0, KFetch);
    step("post-rst-rdy", 1'b1, ISw, 1'b1, KFetchRdy);

    // MEM_WRITE timeout: MemWrite must drop on the trapping cycle.
    step("sw2-decode", 1'b1, ISw, 1'b0, KDecode);
    step("sw2-memadr", 1'b1, ISw, 1'b0, KMemAdr);
    for (int k = 0; k < 15; k++) step("sw2-wait", 1'b1, ISw, 1'b0, KMemWr);
    e = KMemWr; e.MemWrite = 1'b0;
    step("sw2-trap-cycle", 1'b1, ISw, 1'b0, e);
    step("sw2-fault", 1'b1, ISw, 1'b1, KFltTo);
    step("sw2-rst", 1'b0, ISw, 1'b0, KFltTo);

    // Shifts disabled: SLL traps in the EN_SHIFT=0 instance only.
    step("ns-fetch", 1'b1, ISll, 1'b1, KFetchRdy);
    step("ns-decode", 1'b1, ISll, 1'b0, KDecode);
    step("ns-exec", 1'b1, ISll, 1'b0,
         '{st: 4'd6, ALUSrcA: 2'b10, alu_op: 2'b10, alu_funct: 6'h00, default: '0});
    #1;
    check("ns-state", 64'(n_state_o), 64'(4'd15));
    check("ns-fault-code", 64'(n_fault_code), 64'(2'd1));
    check("ns-fault", 64'(n_fault), 64'(1'b1));
    check("ns-ref-state", 64'(state_o), 64'(4'd7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
